// File: rtl/fmesh_route_stage.sv
// Registered routing stage for one fmesh input port: decodes head-flit destinations
// into the coded {x,y,a,b} port plus local-port number, holds the route per packet.
module fmesh_route_stage #(
  parameter int    NX         = 4,
  parameter int    NY         = 4,
  parameter int    NL         = 2,
  parameter int    EAw        = 7,
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    DSTPw      = 4,
  parameter int    PLw        = 3,
  parameter int    Fw         = 32,
  localparam int   EXw        = (NX > 1) ? $clog2(NX) : 1,
  localparam int   EYw        = (NY > 1) ? $clog2(NY) : 1,
  localparam int   EPw        = EAw - EXw - EYw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXw-1:0]   current_x,
  input  logic [EYw-1:0]   current_y,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_hdr,
  input  logic             in_tail,
  input  logic [EAw-1:0]   in_dest_e_addr,
  input  logic [Fw-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSTPw-1:0] out_dest_port_coded,
  output logic [PLw-1:0]   out_endp_localp_num,
  output logic             out_hdr,
  output logic             out_tail,
  output logic [Fw-1:0]    out_data,
  output logic             out_err,
  output logic             dbg_pkt_state
);

  localparam bit ADAPTIVE = (ROUTE_TYPE == "FULL_ADAPTIVE");
  localparam int FLw      = DSTPw + PLw + 3 + Fw;

  typedef enum logic {S_IDLE = 1'b0, S_IN_PKT = 1'b1} state_t;

  // Handshakes (both sides): a transfer happens on a clock edge where valid & ready
  // are both high; a valid producer holds its payload stable until that edge.
  logic             w_in_hs;
  logic             w_out_free;
  logic [EXw-1:0]   w_ex;
  logic [EYw-1:0]   w_ey;
  logic [EPw-1:0]   w_ep;
  logic             w_addr_bad;
  logic             w_a, w_b, w_x, w_y;
  logic [DSTPw-1:0] w_rt_code;
  logic [PLw-1:0]   w_rt_lp;
  logic             w_rt_err;

  state_t           r_state, w_state_nxt;
  logic [DSTPw-1:0] r_rq_code, w_rq_code_nxt;
  logic [PLw-1:0]   r_rq_lp, w_rq_lp_nxt;
  logic [DSTPw-1:0] w_f_code;
  logic [PLw-1:0]   w_f_lp;
  logic             w_f_err;
  logic [FLw-1:0]   w_flit;

  logic             r_out_valid;
  logic [FLw-1:0]   r_out;
  logic             r_skid_valid;
  logic [FLw-1:0]   r_skid;
  logic             r_in_ready;

  assign w_in_hs    = in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  assign w_ex = in_dest_e_addr[EXw-1:0];
  assign w_ey = in_dest_e_addr[EXw+EYw-1:EXw];
  assign w_ep = in_dest_e_addr[EAw-1:EXw+EYw];

  assign w_addr_bad = (int'(w_ex) > NX - 1) | (int'(w_ey) > NY - 1) | (int'(w_ep) > NL + 3);
  assign w_a = (w_ex != current_x);
  assign w_x = (w_ex > current_x);
  assign w_b = (w_ey != current_y);
  assign w_y = (w_ey < current_y);

  // Route decode for the flit on the input; local edge ports get fixed codes.
  always_comb begin
    w_rt_code = '0;
    w_rt_lp   = '0;
    w_rt_err  = 1'b0;
    if (w_addr_bad) begin
      w_rt_err = 1'b1;
    end else if (!w_a && !w_b) begin
      if (w_ep == EPw'(1))      w_rt_code = 4'b1010;
      else if (w_ep == EPw'(2)) w_rt_code = 4'b0101;
      else if (w_ep == EPw'(3)) w_rt_code = 4'b0010;
      else if (w_ep == EPw'(4)) w_rt_code = 4'b0001;
      else                      w_rt_lp   = PLw'(w_ep);
    end else if (!ADAPTIVE && w_a) begin
      w_rt_code = {w_x, 1'b0, 1'b1, 1'b0};
    end else begin
      w_rt_code = {w_x, w_y, w_a, w_b};
    end
  end

  // Packet FSM: next state, route hold and per-flit route/err selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_rq_code_nxt = r_rq_code;
    w_rq_lp_nxt   = r_rq_lp;
    w_f_code      = '0;
    w_f_lp        = '0;
    w_f_err       = 1'b0;
    if (in_hdr) begin
      w_f_code = w_rt_code;
      w_f_lp   = w_rt_lp;
      w_f_err  = w_rt_err | (r_state == S_IN_PKT);
    end else if (r_state == S_IN_PKT) begin
      w_f_code = r_rq_code;
      w_f_lp   = r_rq_lp;
    end else begin
      w_f_err  = 1'b1;
    end
    if (w_in_hs) begin
      if (in_hdr) begin
        w_rq_code_nxt = w_rt_code;
        w_rq_lp_nxt   = w_rt_lp;
        w_state_nxt   = in_tail ? S_IDLE : S_IN_PKT;
      end else if (r_state == S_IN_PKT && in_tail) begin
        w_state_nxt   = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rq_code <= '0;
      r_rq_lp   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rq_code <= w_rq_code_nxt;
      r_rq_lp   <= w_rq_lp_nxt;
    end
  end

  assign w_flit = {w_f_code, w_f_lp, in_hdr, in_tail, w_f_err, in_data};

  // Output register plus skid entry; in_ready only looks at registered state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out        <= r_skid;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_in_hs) begin
          r_out        <= w_flit;
          r_out_valid  <= 1'b1;
        end else begin
          r_out_valid  <= 1'b0;
        end
      end else if (w_in_hs) begin
        r_skid       <= w_flit;
        r_skid_valid <= 1'b1;
      end
      r_in_ready <= w_out_free | ~(r_skid_valid | w_in_hs);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign {out_dest_port_coded, out_endp_localp_num, out_hdr, out_tail, out_err, out_data} = r_out;
  assign dbg_pkt_state = r_state;

endmodule

// File: tb/tb_fmesh_route_stage.sv
// Bench for fmesh_route_stage: XY and fully-adaptive instances share stimulus; a
// scoreboard compares every output flit and the skid occupancy against a reference model.
module tb_fmesh_route_stage;
  localparam int NX = 4, NY = 4, NL = 2, EAw = 7, PLw = 3, Fw = 32;
  localparam int W = 4 + PLw + 3 + Fw;
  localparam int CUR_X = 1, CUR_Y = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    current_x, current_y;
  logic          in_valid, in_hdr, in_tail;
  logic [6:0]    in_dest_e_addr;
  logic [31:0]   in_data;
  logic          out_ready = 1'b1;

  logic          in_ready_d, out_valid_d, out_hdr_d, out_tail_d, out_err_d, dbg_d;
  logic [3:0]    code_d;
  logic [PLw-1:0] lp_d;
  logic [31:0]   data_d;
  logic          in_ready_a, out_valid_a, out_hdr_a, out_tail_a, out_err_a, dbg_a;
  logic [3:0]    code_a;
  logic [PLw-1:0] lp_a;
  logic [31:0]   data_a;

  fmesh_route_stage #(.NX(NX), .NY(NY), .NL(NL), .EAw(EAw), .ROUTE_TYPE("DETERMINISTIC"),
    .DSTPw(4), .PLw(PLw), .Fw(Fw)) dut_det (
    .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
    .in_valid(in_valid), .in_ready(in_ready_d), .in_hdr(in_hdr), .in_tail(in_tail),
    .in_dest_e_addr(in_dest_e_addr), .in_data(in_data), .out_valid(out_valid_d),
    .out_ready(out_ready), .out_dest_port_coded(code_d), .out_endp_localp_num(lp_d),
    .out_hdr(out_hdr_d), .out_tail(out_tail_d), .out_data(data_d), .out_err(out_err_d),
    .dbg_pkt_state(dbg_d));

  fmesh_route_stage #(.NX(NX), .NY(NY), .NL(NL), .EAw(EAw), .ROUTE_TYPE("FULL_ADAPTIVE"),
    .DSTPw(4), .PLw(PLw), .Fw(Fw)) dut_ad (
    .clk(clk), .reset(reset), .current_x(current_x), .current_y(current_y),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_hdr(in_hdr), .in_tail(in_tail),
    .in_dest_e_addr(in_dest_e_addr), .in_data(in_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_dest_port_coded(code_a), .out_endp_localp_num(lp_a),
    .out_hdr(out_hdr_a), .out_tail(out_tail_a), .out_data(data_a), .out_err(out_err_a),
    .dbg_pkt_state(dbg_a));

  logic [W-1:0] dut_word_d, dut_word_a;
  assign dut_word_d = {code_d, lp_d, out_hdr_d, out_tail_d, out_err_d, data_d};
  assign dut_word_a = {code_a, lp_a, out_hdr_a, out_tail_a, out_err_a, data_a};

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_ad_q[$];
  bit   mon_en = 1'b0;
  int   rdy_mode = 0;
  int   pat_idx = 0;
  bit   rdy_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  bit         m_in_pkt = 1'b0;
  logic [6:0] m_pkt_addr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [3:0] code, input logic [2:0] lp,
                                        input logic h, input logic t, input logic e,
                                        input logic [31:0] d);
    return {code, lp, h, t, e, d};
  endfunction

  function automatic logic [6:0] mk(input int ep, input int ey, input int ex);
    logic [6:0] a;
    a = {3'(ep), 2'(ey), 2'(ex)};
    return a;
  endfunction

  // Returns {err, localp, code} from hop distances to the destination router.
  function automatic logic [7:0] route_model(input bit adaptive, input logic [6:0] addr);
    int ex, ey, ep, dx, dy;
    logic [3:0] code;
    logic [2:0] lp;
    ex = int'(addr[1:0]);
    ey = int'(addr[3:2]);
    ep = int'(addr[6:4]);
    code = '0;
    lp = '0;
    if (ex > NX - 1 || ey > NY - 1 || ep > NL + 3) return {1'b1, 3'd0, 4'd0};
    dx = ex - CUR_X;
    dy = ey - CUR_Y;
    if (dx == 0 && dy == 0) begin
      case (ep)
        1: code = 4'b1010;
        2: code = 4'b0101;
        3: code = 4'b0010;
        4: code = 4'b0001;
        default: lp = 3'(ep);
      endcase
    end else if (!adaptive && dx != 0) begin
      code = {dx > 0, 1'b0, 1'b1, 1'b0};
    end else begin
      code = {dx > 0, dy < 0, dx != 0, dy != 0};
    end
    return {1'b0, lp, code};
  endfunction

  function automatic void model_flit(input logic h, input logic t, input logic [6:0] a,
                                     input logic [31:0] d, output logic [W-1:0] ed,
                                     output logic [W-1:0] ea);
    logic [7:0] rd, ra;
    if (h) begin
      rd = route_model(1'b0, a);
      ra = route_model(1'b1, a);
      ed = pack(rd[3:0], rd[6:4], h, t, rd[7] | m_in_pkt, d);
      ea = pack(ra[3:0], ra[6:4], h, t, ra[7] | m_in_pkt, d);
      m_pkt_addr = a;
      m_in_pkt = !t;
    end else if (m_in_pkt) begin
      rd = route_model(1'b0, m_pkt_addr);
      ra = route_model(1'b1, m_pkt_addr);
      ed = pack(rd[3:0], rd[6:4], h, t, 1'b0, d);
      ea = pack(ra[3:0], ra[6:4], h, t, 1'b0, d);
      m_in_pkt = !t;
    end else begin
      ed = pack(4'd0, 3'd0, h, t, 1'b1, d);
      ea = ed;
    end
  endfunction

  // Drives one flit, waits (bounded) for acceptance and queues its expected output.
  task automatic send(input logic h, input logic t, input logic [6:0] a, input logic [31:0] d,
                      input bit lit, input logic [W-1:0] ld, input logic [W-1:0] la);
    logic [W-1:0] ed, ea;
    int waited;
    in_valid = 1'b1;
    in_hdr = h;
    in_tail = t;
    in_dest_e_addr = a;
    in_data = d;
    waited = 0;
    @(negedge clk);
    while (!in_ready_d && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_d) begin
      chk("send_timeout", 64'(in_ready_d), 64'd1);
      in_valid = 1'b0;
      return;
    end
    model_flit(h, t, a, d, ed, ea);
    if (lit) begin
      ed = ld;
      ea = la;
    end
    exp_q.push_back(ed);
    exp_ad_q.push_back(ea);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_lit(input logic h, input logic t, input logic [6:0] a, input logic [31:0] d,
                          input logic [3:0] cd, input logic [3:0] ca, input logic [2:0] lp,
                          input logic e);
    send(h, t, a, d, 1'b1, pack(cd, lp, h, t, e, d), pack(ca, lp, h, t, e, d));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("in_ready_before_first_edge", 64'(in_ready_d), 64'd0);
    @(posedge clk);
    #1;
    chk("in_ready_after_first_edge", 64'(in_ready_d), 64'd1);
    chk("in_ready_after_first_edge_ad", 64'(in_ready_a), 64'd1);
    mon_en = 1'b1;
  endtask

  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 2) != 0);
      2: begin
        out_ready = (pat_idx < 7) ? rdy_pat[pat_idx] : 1'b1;
        pat_idx++;
      end
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: occupancy model of output reg + skid, stall hold, and scoreboard pops.
  int occ = 0;
  bit stall_prev = 1'b0;
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    if (!mon_en) begin
      occ = 0;
      stall_prev = 1'b0;
    end else begin
      chk("out_valid_vs_occupancy", 64'(out_valid_d), 64'(occ > 0));
      chk("out_valid_ad_vs_occupancy", 64'(out_valid_a), 64'(occ > 0));
      chk("in_ready_vs_occupancy", 64'(in_ready_d), 64'(occ < 2));
      if (stall_prev) chk("stall_hold", 64'(dut_word_d), 64'(held));
      if (out_valid_d && out_ready) begin
        if (exp_q.size() == 0 || exp_ad_q.size() == 0) begin
          chk("unexpected_output", 64'(dut_word_d), 64'd0);
          n_fail += (dut_word_d == '0) ? 1 : 0;
        end else begin
          chk("flit_det", 64'(dut_word_d), 64'(exp_q.pop_front()));
          chk("flit_adaptive", 64'(dut_word_a), 64'(exp_ad_q.pop_front()));
        end
      end
      stall_prev = out_valid_d && !out_ready;
      held = dut_word_d;
      occ = occ + ((in_valid && in_ready_d) ? 1 : 0) - ((out_valid_d && out_ready) ? 1 : 0);
    end
  end

  initial begin
    int len, waited;
    logic h, t;
    reset = 1'b0;
    current_x = 2'(CUR_X);
    current_y = 2'(CUR_Y);
    in_valid = 1'b0;
    in_hdr = 1'b0;
    in_tail = 1'b0;
    in_dest_e_addr = '0;
    in_data = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid_d), 64'd0);
    chk("rst_in_ready", 64'(in_ready_d), 64'd0);
    chk("rst_out_word", 64'(dut_word_d), 64'd0);
    chk("rst_out_word_ad", 64'(dut_word_a), 64'd0);
    chk("rst_fsm_idle", 64'({dbg_d, dbg_a}), 64'd0);
    repeat (2) @(posedge clk);
    release_reset();

    // Directed routes from router (1,2).
    send_lit(1, 1, mk(0, 2, 3), 32'h1000_0001, 4'b1010, 4'b1010, 3'd0, 1'b0);
    send_lit(1, 1, mk(0, 0, 3), 32'h1000_0002, 4'b1010, 4'b1111, 3'd0, 1'b0);
    send_lit(1, 1, mk(0, 0, 1), 32'h1000_0003, 4'b0101, 4'b0101, 3'd0, 1'b0);
    send_lit(1, 1, mk(5, 2, 1), 32'h1000_0004, 4'b0000, 4'b0000, 3'd5, 1'b0);
    send_lit(1, 1, mk(3, 2, 1), 32'h1000_0005, 4'b0010, 4'b0010, 3'd0, 1'b0);
    send_lit(1, 1, mk(7, 2, 1), 32'h1000_0006, 4'b0000, 4'b0000, 3'd0, 1'b1);
    send_lit(1, 1, mk(6, 2, 1), 32'h1000_0007, 4'b0000, 4'b0000, 3'd0, 1'b1);
    send_lit(1, 1, mk(4, 2, 1), 32'h1000_0008, 4'b0001, 4'b0001, 3'd0, 1'b0);
    send_lit(1, 1, mk(0, 2, 1), 32'h1000_0009, 4'b0000, 4'b0000, 3'd0, 1'b0);

    // 4-flit packet under a fixed out_ready pattern; body addresses are ignored.
    pat_idx = 0;
    rdy_mode = 2;
    send_lit(1, 0, mk(0, 3, 0), 32'h2000_0000, 4'b0010, 4'b0011, 3'd0, 1'b0);
    send_lit(0, 0, 7'h7f, 32'h2000_0001, 4'b0010, 4'b0011, 3'd0, 1'b0);
    send_lit(0, 0, 7'h00, 32'h2000_0002, 4'b0010, 4'b0011, 3'd0, 1'b0);
    send_lit(0, 1, 7'h55, 32'h2000_0003, 4'b0010, 4'b0011, 3'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rdy_mode = 0;

    // Protocol errors: body in IDLE, head inside a packet.
    send_lit(0, 0, mk(0, 2, 3), 32'h3000_0000, 4'b0000, 4'b0000, 3'd0, 1'b1);
    send_lit(1, 0, mk(0, 2, 2), 32'h3000_0001, 4'b1010, 4'b1010, 3'd0, 1'b0);
    send_lit(1, 0, mk(0, 3, 1), 32'h3000_0002, 4'b0001, 4'b0001, 3'd0, 1'b1);
    send_lit(0, 1, 7'h00, 32'h3000_0003, 4'b0001, 4'b0001, 3'd0, 1'b0);

    // Randomised packets, occasional malformed heads, random backpressure and gaps.
    rdy_mode = 1;
    for (int p = 0; p < 120; p++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        h = (i == 0);
        t = (i == len - 1);
        if ($urandom_range(0, 19) == 0) h = ~h;
        send(h, t, 7'($urandom_range(0, 127)), $urandom, 1'b0, '0, '0);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end

    // Reset with a stalled flit in the output register and one in the skid buffer.
    rdy_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    rdy_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    send(1, 0, mk(0, 3, 3), 32'h4000_0000, 1'b0, '0, '0);
    send(0, 0, 7'h00, 32'h4000_0001, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("skid_full_in_ready_low", 64'(in_ready_d), 64'd0);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid_d), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_d), 64'd0);
    chk("midrst_out_word", 64'(dut_word_d), 64'd0);
    chk("midrst_fsm_idle", 64'({dbg_d, dbg_a}), 64'd0);
    exp_q.delete();
    exp_ad_q.delete();
    m_in_pkt = 1'b0;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    release_reset();
    send_lit(1, 1, mk(5, 2, 1), 32'h5000_0000, 4'b0000, 4'b0000, 3'd5, 1'b0);
    send_lit(1, 1, mk(0, 0, 3), 32'h5000_0001, 4'b1010, 4'b1111, 3'd0, 1'b0);

    waited = 0;
    while ((exp_q.size() != 0 || out_valid_d) && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
